// File: rtl/mem_arbiter.sv
// Two-requester (instruction / data) arbiter in front of a single SRAM-like
// memory port. Only one transaction is outstanding at a time. The winning
// request is latched on acceptance and replayed to memory until it is taken.
module mem_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_q, state_d;
  logic        owner_q;   // 1 = data requester owns (or last owned) the port
  logic        wr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        grant;
  logic        grant_data;
  logic        done;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state, handshake and completion decode.
  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    mem_req      = 1'b0;
    done         = 1'b0;
    // On a tie the data side wins outright, or alternates away from the last owner.
    grant_data   = data_req && (!inst_req || DATA_PRIO || !owner_q);
    case (state_q)
      IDLE: begin
        // resetn gate keeps the handshakes quiet while reset is held.
        if (resetn && (inst_req || data_req)) begin
          grant        = 1'b1;
          data_addr_ok = grant_data;
          inst_addr_ok = !grant_data;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    inst_data_ok = done && !owner_q;
    data_data_ok = done &&  owner_q;
  end

  // Capture the winning request; previous owner resets to data so the first
  // round-robin tie goes to the instruction side.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= 1'b1;
      wr_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= grant_data;
      wr_q    <= grant_data && data_wr;
      wstrb_q <= grant_data ? data_wstrb : 4'b0000;
      addr_q  <= grant_data ? data_addr  : inst_addr;
      wdata_q <= grant_data ? data_wdata : '0;
    end
  end

  assign mem_wr     = wr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

  // Read data is broadcast; the owner's data_ok is the only qualifier.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;

  // second instance, round-robin ties
  logic        b_inst_req, b_data_req, b_mem_addr_ok, b_mem_data_ok;
  logic        b_iao, b_ido, b_dao, b_ddo, b_mreq, b_mwr;
  logic [31:0] b_ird, b_drd, b_maddr, b_mwdata;
  logic [3:0]  b_mwstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_PRIO(1'b1)) u0 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.DATA_PRIO(1'b0)) u1 (
    .clk(clk), .resetn(resetn),
    .inst_req(b_inst_req), .inst_addr(inst_addr), .inst_addr_ok(b_iao),
    .inst_data_ok(b_ido), .inst_rdata(b_ird),
    .data_req(b_data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(b_dao),
    .data_data_ok(b_ddo), .data_rdata(b_drd),
    .mem_req(b_mreq), .mem_wr(b_mwr), .mem_wstrb(b_mwstrb), .mem_addr(b_maddr),
    .mem_wdata(b_mwdata), .mem_addr_ok(b_mem_addr_ok), .mem_data_ok(b_mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // ---------------- transaction-level reference model (u0, data priority) --
  bit          m_busy, m_sent, m_prev_data, m_own_data;
  bit          m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  bit          m_acc_i, m_acc_d;

  always @(negedge clk) begin
    bit e_iao, e_dao, e_ido, e_ddo, e_mreq, win_d, fin;
    e_iao = 0; e_dao = 0; e_ido = 0; e_ddo = 0; e_mreq = 0; win_d = 0; fin = 0;
    m_acc_i = 0; m_acc_d = 0;
    if (!resetn) begin
      m_busy = 0; m_sent = 0; m_prev_data = 1;
      chk("rst_mem_addr",  mem_addr,  32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wr",    mem_wr,    32'h0);
      chk("rst_mem_wstrb", mem_wstrb, 32'h0);
    end else if (!m_busy) begin
      if (inst_req || data_req) begin
        win_d = data_req;  // data side always wins a tie in this instance
        e_dao = win_d;
        e_iao = !win_d;
      end
    end else begin
      e_mreq = !m_sent;
      fin = m_sent ? mem_data_ok : (mem_addr_ok && mem_data_ok);
      e_ddo = fin && m_own_data;
      e_ido = fin && !m_own_data;
    end
    chk("inst_addr_ok", inst_addr_ok, e_iao);
    chk("data_addr_ok", data_addr_ok, e_dao);
    chk("inst_data_ok", inst_data_ok, e_ido);
    chk("data_data_ok", data_data_ok, e_ddo);
    chk("mem_req",      mem_req,      e_mreq);
    chk("inst_rdata",   inst_rdata,   mem_rdata);
    chk("data_rdata",   data_rdata,   mem_rdata);
    if (e_mreq) begin
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wr",    mem_wr,    m_wr);
      chk("mem_wstrb", mem_wstrb, m_wstrb);
      if (m_own_data) chk("mem_wdata", mem_wdata, m_wdata);
    end
    // advance model to the next cycle
    if (resetn) begin
      if (e_iao || e_dao) begin
        m_busy = 1; m_sent = 0; m_own_data = win_d; m_prev_data = win_d;
        m_acc_i = e_iao; m_acc_d = e_dao;
        m_addr  = win_d ? data_addr : inst_addr;
        m_wr    = win_d && data_wr;
        m_wstrb = win_d ? data_wstrb : 4'h0;
        m_wdata = data_wdata;
      end else if (fin) begin
        m_busy = 0;
      end else if (m_busy && !m_sent && mem_addr_ok) begin
        m_sent = 1;
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  bit inst_pend, data_pend;
  int rst_cnt;

  initial begin
    resetn = 0; inst_req = 1; data_req = 1; data_wr = 0; data_wstrb = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 32'h5a5a0000;
    mem_addr_ok = 1; mem_data_ok = 1;
    b_inst_req = 0; b_data_req = 0; b_mem_addr_ok = 0; b_mem_data_ok = 0;
    step(); settle();
    // reset: requests and responses present, yet every handshake stays low
    chk("reset_inst_addr_ok", inst_addr_ok, 0);
    chk("reset_data_addr_ok", data_addr_ok, 0);
    chk("reset_mem_req",      mem_req,      0);
    chk("reset_data_rdata",   data_rdata,   32'h5a5a0000);
    step(); inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    step(); resetn = 1;

    // single instruction read
    step(); inst_req = 1; inst_addr = 32'h1c000000; settle();
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    step(); inst_req = 0; mem_addr_ok = 1; settle();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h1c000000);
    chk("t1_mem_wr", mem_wr, 0);
    chk("t1_inst_addr_ok_busy", inst_addr_ok, 0);
    step(); mem_addr_ok = 0; settle();
    chk("t1_mem_req_drop", mem_req, 0);
    chk("t1_no_early_data_ok", inst_data_ok, 0);
    step(); mem_data_ok = 1; mem_rdata = 32'h02800000; settle();
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_inst_rdata", inst_rdata, 32'h02800000);
    chk("t1_data_data_ok", data_data_ok, 0);
    step(); mem_data_ok = 0; settle();
    chk("t1_data_ok_one_cycle", inst_data_ok, 0);

    // tie with data priority, data write completes with same-cycle handshakes
    step(); inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_addr = 32'h1000; data_wdata = 32'hdeadbeef; data_wstrb = 4'hf;
    settle();
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok", inst_addr_ok, 0);
    step(); data_req = 0; mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h12345678; settle();
    chk("t2_mem_wr", mem_wr, 1);
    chk("t2_mem_addr", mem_addr, 32'h1000);
    chk("t2_mem_wdata", mem_wdata, 32'hdeadbeef);
    chk("t2_mem_wstrb", mem_wstrb, 32'hf);
    chk("t2_same_cycle_data_ok", data_data_ok, 1);
    chk("t2_inst_waits", inst_addr_ok, 0);
    step(); mem_addr_ok = 0; mem_data_ok = 0; settle();
    chk("t2_mem_req_low", mem_req, 0);
    chk("t2_inst_accept_next", inst_addr_ok, 1);

    // backpressure: five cycles without mem_addr_ok, a data request waits
    step(); inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h2000; data_wstrb = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      mem_addr_ok = (i == 5);
      settle();
      chk("t3_mem_req", mem_req, 1);
      chk("t3_mem_addr", mem_addr, 32'h1c000004);
      chk("t3_mem_wr", mem_wr, 0);
      chk("t3_mem_wstrb", mem_wstrb, 0);
      chk("t3_no_data_addr_ok", data_addr_ok, 0);
    end
    step(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'ha5a50001; settle();
    chk("t3_inst_data_ok", inst_data_ok, 1);
    chk("t3_inst_rdata", inst_rdata, 32'ha5a50001);
    chk("t3_data_still_waits", data_addr_ok, 0);
    step(); mem_data_ok = 0; settle();
    chk("t3_data_accept", data_addr_ok, 1);

    // reset while waiting for data
    step(); data_req = 0; mem_addr_ok = 1; settle();
    chk("t4_mem_addr", mem_addr, 32'h2000);
    step(); mem_addr_ok = 0; settle();
    chk("t4_in_data_phase", mem_req, 0);
    step(); resetn = 0; mem_data_ok = 1; settle();
    chk("t4_rst_data_data_ok", data_data_ok, 0);
    chk("t4_rst_mem_addr", mem_addr, 0);
    step(); mem_data_ok = 0; resetn = 1;
    step(); mem_data_ok = 1; settle();
    chk("t4_late_resp_ignored", data_data_ok, 0);
    chk("t4_late_resp_ignored_i", inst_data_ok, 0);
    step(); mem_data_ok = 0; data_req = 1; settle();
    chk("t4_idle_after_reset", data_addr_ok, 1);
    step(); data_req = 0; mem_addr_ok = 1; mem_data_ok = 1; settle();
    chk("t4_next_complete", data_data_ok, 1);
    step(); mem_addr_ok = 0; mem_data_ok = 0;

    // round-robin instance: three ties after reset -> inst, data, inst
    b_inst_req = 1; b_data_req = 1; b_mem_addr_ok = 1; b_mem_data_ok = 1;
    inst_addr = 32'h1c000100; data_addr = 32'h3000; data_wr = 1; data_wstrb = 4'h3;
    data_wdata = 32'hcafef00d;
    for (int k = 0; k < 6; k++) begin
      bit own_d;
      own_d = ((k / 2) % 2) == 1;
      if (k > 0) step();
      settle();
      if (k % 2 == 0) begin
        chk("rr_inst_addr_ok", b_iao, !own_d);
        chk("rr_data_addr_ok", b_dao, own_d);
      end else begin
        chk("rr_mem_req", b_mreq, 1);
        chk("rr_mem_addr", b_maddr, own_d ? 32'h3000 : 32'h1c000100);
        chk("rr_mem_wr", b_mwr, own_d);
        chk("rr_mem_wstrb", b_mwstrb, own_d ? 32'h3 : 32'h0);
        if (own_d) chk("rr_mem_wdata", b_mwdata, 32'hcafef00d);
        chk("rr_inst_data_ok", b_ido, !own_d);
        chk("rr_data_data_ok", b_ddo, own_d);
        chk("rr_rdata", b_ird | b_drd, mem_rdata);
      end
    end
    step(); b_inst_req = 0; b_data_req = 0; b_mem_addr_ok = 0; b_mem_data_ok = 0;
    data_wr = 0;

    // randomized traffic with spurious responses and occasional resets
    inst_pend = 0; data_pend = 0; rst_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) resetn = 1;
      end else if ($urandom_range(0, 199) == 0) begin
        resetn = 0;
        rst_cnt = $urandom_range(1, 3);
      end
      if (m_acc_i) inst_pend = 0;
      if (m_acc_d) data_pend = 0;
      if (!inst_pend && $urandom_range(0, 2) == 0) begin
        inst_pend = 1;
        inst_addr = $urandom;
      end
      if (!data_pend && $urandom_range(0, 2) == 0) begin
        data_pend = 1;
        data_wr = $urandom_range(0, 1) == 1;
        data_wstrb = 4'($urandom_range(0, 15));
        data_addr = $urandom;
        data_wdata = $urandom;
      end
      inst_req = inst_pend;
      data_req = data_pend;
      mem_addr_ok = $urandom_range(0, 1) == 1;
      mem_data_ok = $urandom_range(0, 2) == 0;
      mem_rdata = $urandom;
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_PRIO, default 1: 1 = data requester always wins ties; 0 = round-robin on ties.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port inst_req  in  1  instruction read request.
REQ-005 SHALL have port inst_addr  in  32  instruction byte address.
REQ-006 SHALL have port inst_addr_ok  out  1  instruction request accepted this cycle.
REQ-007 SHALL have port inst_data_ok  out  1  instruction read data valid this cycle.
REQ-008 SHALL have port inst_rdata  out  32  instruction read data.
REQ-009 SHALL have port data_req  in  1  data request.
REQ-010 SHALL have port data_wr  in  1  1 = write, 0 = read.
REQ-011 SHALL have port data_wstrb  in  4  byte write enables.
REQ-012 SHALL have port data_addr  in  32  data byte address.
REQ-013 SHALL have port data_wdata  in  32  write data.
REQ-014 SHALL have port data_addr_ok  out  1  data request accepted this cycle.
REQ-015 SHALL have port data_data_ok  out  1  data transaction complete (read data valid or write done).
REQ-016 SHALL have port data_rdata  out  32  data read data.
REQ-017 SHALL have ports mem_req/mem_wr (out 1), mem_wstrb (out 4), mem_addr/mem_wdata (out 32): shared downstream request.
REQ-018 SHALL have ports mem_addr_ok/mem_data_ok (in 1), mem_rdata (in 32): downstream responses.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, DATA; at most one transaction outstanding.
REQ-020 IDLE: if any requester asserts req, SHALL pick a winner, pulse that requester's addr_ok for one cycle, latch wr/wstrb/addr/wdata into internal registers, record owner, and go to ADDR next cycle.
REQ-021 Winner selection: only one req -> that requester; both req with DATA_PRIO=1 -> data; with DATA_PRIO=0 -> the requester that did not own the previous transaction.
REQ-022 An inst winner SHALL latch wr=0 and wstrb=4'b0000.
REQ-023 ADDR: SHALL drive mem_req=1 and mem_wr/mem_wstrb/mem_addr/mem_wdata from the latched registers, held stable until mem_addr_ok=1; then go to DATA.
REQ-024 DATA: mem_req=0; on mem_data_ok=1 SHALL assert the owner's data_ok in that same cycle (combinational) and return to IDLE.
REQ-025 mem_addr_ok and mem_data_ok both 1 in the same ADDR cycle SHALL complete the transaction: owner data_ok that cycle, next state IDLE.
REQ-026 mem_data_ok in IDLE, or mem_addr_ok outside ADDR, SHALL be ignored.
REQ-027 inst_rdata and data_rdata SHALL both equal mem_rdata at all times; only the owner's data_ok qualifies it.
REQ-028 addr_ok SHALL never be asserted outside IDLE; new requests wait (req held by requester) until IDLE.
REQ-029 Minimum latency: accept at cycle N, mem_req at N+1, earliest data_ok at N+1; back-to-back transaction accept earliest the cycle after data_ok.
REQ-030 Non-owner data_ok SHALL be 0 at all times.

Reset
REQ-031 resetn=0 SHALL immediately (asynchronously) force state IDLE, all latched fields 0, and previous-owner = data, so the first round-robin tie goes to inst.
REQ-032 During reset all outputs SHALL be 0, except inst_rdata/data_rdata, which follow mem_rdata.
REQ-033 Reset mid-transaction SHALL abandon it without any data_ok; responses arriving after release in IDLE are ignored (REQ-026).

Verification
REQ-034 Single inst read: inst_req=1, addr 0x1c000000; mem_addr_ok next cycle, mem_data_ok 2 cycles later with rdata 0x02800000 -> one inst_addr_ok pulse, mem_req one cycle, mem_addr=0x1c000000, mem_wr=0, inst_data_ok one cycle with inst_rdata=0x02800000.
REQ-035 Tie, DATA_PRIO=1: both req same cycle, data write addr 0x1000 wdata 0xdeadbeef wstrb 0xf -> data wins, mem_wr=1; inst accepted in IDLE after data_data_ok.
REQ-036 Tie, DATA_PRIO=0: three consecutive ties after reset -> grant order inst, data, inst.
REQ-037 Backpressure: mem_addr_ok low 5 cycles -> mem_req and all mem_* fields stable for 6 cycles; no addr_ok to any requester meanwhile.
REQ-038 Same-cycle addr_ok/data_ok in ADDR -> owner data_ok that cycle, mem_req low next cycle, new request accepted next cycle.
REQ-039 Reset in DATA: deassert resetn, then release, then pulse mem_data_ok -> no data_ok asserted, all outputs 0 while in reset, FSM in IDLE.
